// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M MUL/DIV/DIVU/REM/REMU unit for the EX stage
// Ports: clk_i/rst_i (async high), req_i/flush_i/funct_i/data1_i/data2_i in;
//        stall_o (comb), done_o (1-cycle pulse), result_o (held until next done) out.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero MUL
// operands finish directly from IDLE.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            flush_i,
    input  logic [9:0]      funct_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] a_q, b_q, acc_q, out_q, m1, m2, fin;
    logic [XLEN:0] t, d;
    logic op_mul_q, op_rem_q, neg_q_q, neg_r_q;
    logic legal, sgn, n1, n2, div0, accept, early;
    always_comb begin
        legal  = funct_i[9:3] == 7'b0000001 && (funct_i[2:0] == 3'b000 || funct_i[2]);
        sgn    = funct_i[2] & ~funct_i[0];
        n1     = sgn & data1_i[XLEN-1];
        n2     = sgn & data2_i[XLEN-1];
        m1     = n1 ? -data1_i : data1_i;
        m2     = n2 ? -data2_i : data2_i;
        div0   = funct_i[2] && data2_i == '0;
        accept = state_q == IDLE && req_i && legal && !flush_i;
`ifdef MULDIV_EARLY_OUT_EN
        early  = funct_i[2] ? (div0 || (sgn && data1_i == {1'b1, {(XLEN-1){1'b0}}} && data2_i == '1))
                            : (data1_i == '0 || data2_i == '0);
`else
        early  = 1'b0;
`endif
        // restoring division: shift next dividend bit into the partial remainder
        t      = {acc_q, a_q[XLEN-1]};
        d      = t - {1'b0, b_q};
        fin    = op_mul_q ? acc_q : op_rem_q ? (neg_r_q ? -acc_q : acc_q) : (neg_q_q ? -a_q : a_q);
    end
    always_comb begin
        state_d = flush_i ? IDLE :
                  state_q == IDLE ? (accept ? (early ? DONE : BUSY) : IDLE) :
                  state_q == BUSY ? (cnt_q == CNT_W'(XLEN-1) ? DONE : BUSY) : IDLE;
        stall_o  = (state_q == IDLE && req_i && legal) || state_q == BUSY;
        done_o   = state_q == DONE && !flush_i;
        result_o = done_o ? fin : out_q;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            op_mul_q <= 1'b0;
            op_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q    <= '0;
                op_mul_q <= funct_i[2:0] == 3'b000;
                op_rem_q <= funct_i[1];
                // a divide by zero keeps the all-ones quotient unsigned
                neg_q_q  <= (n1 ^ n2) && !div0;
                neg_r_q  <= n1;
                // early divide-by-zero preloads quotient=all ones, remainder=|dividend|
                a_q      <= (early && div0) ? '1 : m1;
                acc_q    <= (early && div0) ? m1 : '0;
                b_q      <= m2;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q + 1'b1;
                if (op_mul_q) begin
                    acc_q <= acc_q + (a_q[0] ? b_q : '0);
                    a_q   <= a_q >> 1;
                    b_q   <= b_q << 1;
                end else begin
                    acc_q <= d[XLEN] ? t[XLEN-1:0] : d[XLEN-1:0];
                    a_q   <= {a_q[XLEN-2:0], ~d[XLEN]};
                end
            end
            if (done_o) out_q <= fin;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [9:0]  funct_i = '0;
    logic [31:0] data1_i = '0;
    logic [31:0] data2_i = '0;
    logic        stall_o, done_o;
    logic [31:0] result_o;
    int total = 0;
    int bad = 0;
    logic [31:0] last_e = '0;

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .flush_i(flush_i),
        .funct_i(funct_i), .data1_i(data1_i), .data2_i(data2_i),
        .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = longint'({32'h0, a}) * longint'({32'h0, b});
        case (f3)
            3'b000:  return p[31:0];
            3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_early(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 == 3'b000) return a == 0 || b == 0;
        return b == 0 || ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit hold);
        logic [31:0] e;
        int lat, got, sbad;
        e = ref_res(f3, a, b);
        lat = 33;
`ifdef MULDIV_EARLY_OUT_EN
        if (is_early(f3, a, b)) lat = 1;
`endif
        @(negedge clk_i);
        funct_i = {7'b0000001, f3};
        data1_i = a;
        data2_i = b;
        req_i = 1'b1;
        #1 check("stall_accept", 32'(stall_o), 1);
        @(posedge clk_i);
        #1 if (!hold) req_i = 1'b0;
        got = 0;
        sbad = 0;
        for (int j = 1; j <= 40 && got == 0; j++) begin
            @(negedge clk_i);
            if (done_o) got = j;
            else if (stall_o !== 1'b1) sbad++;
        end
        req_i = 1'b0;
        check("stall_busy", 32'(sbad), 0);
        check("latency", 32'(got), 32'(lat));
        check("result", result_o, e);
        check("stall_done", 32'(stall_o), 0);
        @(negedge clk_i);
        check("result_hold", result_o, e);
        check("done_low", 32'(done_o), 0);
        check("stall_idle", 32'(stall_o), 0);
        last_e = e;
    endtask

    initial begin
        logic [2:0] ops [5];
        logic [31:0] ra, rb;
        ops = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
        #1;
        check("rst_stall", 32'(stall_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_result", result_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        op(3'b000, 32'd7, 32'hFFFF_FFFD, 0);
        op(3'b100, -32'sd20, 32'd3, 0);
        op(3'b110, -32'sd20, 32'd3, 0);
        op(3'b101, 32'd20, 32'd3, 0);
        op(3'b111, 32'd20, 32'd3, 0);
        op(3'b100, 32'd5, 32'd0, 0);
        op(3'b110, 32'd5, 32'd0, 0);
        op(3'b101, 32'd5, 32'd0, 0);
        op(3'b111, 32'd5, 32'd0, 0);
        op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        op(3'b000, 32'd0, 32'h1234_5678, 0);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 7))
                0: ra = 32'h0;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            op(ops[$urandom_range(0, 4)], ra, rb, 0);
        end

        // flush a DIV in cycle T0+10; next op accepted in T0+11
        @(negedge clk_i);
        funct_i = 10'b0000001_100;
        data1_i = 32'd100;
        data2_i = 32'd7;
        req_i = 1'b1;
        @(posedge clk_i);
        #1 req_i = 1'b0;
        repeat (10) @(negedge clk_i);
        flush_i = 1'b1;
        #1 check("flush_done", 32'(done_o), 0);
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        check("flush_idle_stall", 32'(stall_o), 0);
        check("flush_done_after", 32'(done_o), 0);
        check("flush_result", result_o, last_e);
        op(3'b101, 32'd100, 32'd7, 0);

        // async reset mid-MUL
        @(negedge clk_i);
        funct_i = 10'b0000001_000;
        data1_i = 32'd123;
        data2_i = 32'd456;
        req_i = 1'b1;
        @(posedge clk_i);
        #1 req_i = 1'b0;
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("midrst_stall", 32'(stall_o), 0);
        check("midrst_done", 32'(done_o), 0);
        check("midrst_result", result_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (40) @(negedge clk_i);
        check("midrst_no_done", 32'(done_o), 0);
        check("midrst_result_kept", result_o, 0);

        // illegal functs never stall
        @(negedge clk_i);
        funct_i = 10'b0000000_000;
        req_i = 1'b1;
        #1 check("add_stall", 32'(stall_o), 0);
        funct_i = 10'b0000001_001;
        #1 check("mulh_stall", 32'(stall_o), 0);
        repeat (40) @(negedge clk_i);
        check("mulh_no_done", 32'(done_o), 0);
        check("mulh_result", result_o, 0);
        req_i = 1'b0;

        op(3'b000, 32'd1000, 32'd1000, 1);
        repeat (3) @(negedge clk_i);
        check("hold_no_second", 32'(stall_o), 0);
        check("hold_no_done", 32'(done_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
